hdmi_timing_gen: RTL and testbench

Parametrised HDMI raster timing generator and period scheduler for the `clk_pixel` domain. It replaces the fixed video-ID-code timing in the HDMI top with fully parametric front porch, sync, back porch and polarity. It adds demand-driven data-island scheduling: packets are requested from an upstream packet source via a valid/ready handshake, and up to `PKT_SLOTS` packets are placed in the horizontal blanking of any line. Its outputs drive the three `tmds_channel` instances, `mode`/`ctrl`, and the packet serializer.

---
 rtl/hdmi_timing_gen.sv | 141 ++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: parametric HDMI raster timing with demand-driven data-island scheduling
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter bit DVI_OUTPUT = 1'b0,
  parameter int ISLAND_OFFSET = 2,
  parameter int MAX_PACKETS = 18,
  parameter int BIT_WIDTH = 11,
  parameter int BIT_HEIGHT = 10
) (
  input  logic                clk_pixel,
  input  logic                reset_n,
  input  logic                packet_valid,
  output logic [BIT_WIDTH:0]  cx,
  output logic [BIT_HEIGHT:0] cy,
  output logic                hsync,
  output logic                vsync,
  output logic [2:0]          mode,
  output logic [3:0]          ctrl,
  output logic                packet_ready,
  output logic                packet_first,
  output logic [4:0]          slot_cycle,
  output logic                frame_start
);
  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int FW = H_BLANK + H_ACTIVE;
  localparam int FH = V_BLANK + V_ACTIVE;
  localparam int SLOTS_RAW = (H_BLANK - ISLAND_OFFSET - 34) / 32;
  localparam int PKT_SLOTS = SLOTS_RAW < 0 ? 0 : (SLOTS_RAW > MAX_PACKETS ? MAX_PACKETS : SLOTS_RAW);
  localparam bit ISL_OK = !DVI_OUTPUT && PKT_SLOTS > 0;
  localparam int CW = BIT_WIDTH + 1;
  localparam int RW = BIT_HEIGHT + 1;
  localparam logic [CW-1:0] CX_LAST = CW'(FW - 1);
  localparam logic [RW-1:0] CY_LAST = RW'(FH - 1);
  localparam logic [CW-1:0] HB = CW'(H_BLANK);
  localparam logic [CW-1:0] HB_PRE = CW'(H_BLANK - 10);
  localparam logic [CW-1:0] HB_GRD = CW'(H_BLANK - 2);
  localparam logic [CW-1:0] HS_ON = CW'(H_FRONT);
  localparam logic [CW-1:0] HS_OFF = CW'(H_FRONT + H_SYNC);
  localparam logic [RW-1:0] VB = RW'(V_BLANK);
  localparam logic [RW-1:0] VS_ON = RW'(V_FRONT);
  localparam logic [RW-1:0] VS_OFF = RW'(V_FRONT + V_SYNC);
  localparam logic [CW-1:0] ISL_X = CW'(ISLAND_OFFSET);

  typedef enum logic [2:0] {CTRL, ISL_PRE, ISL_GUARD_L, ISL_DATA, ISL_GUARD_T} state_t;

  state_t state, state_n;
  logic run;
  logic [CW-1:0] cx_n;
  logic [RW-1:0] cy_n;
  logic [4:0] cnt, cnt_n;
  logic [7:0] slots, slots_n;
  logic v_line;

  // Everything below is computed for the pixel about to be presented, so registering it keeps zero-offset alignment.
  // Raster position of the next pixel; the first edge after reset re-presents (0,0) to flag frame_start.
  always_comb begin
    cx_n = run ? ((cx == CX_LAST) ? '0 : cx + 1'b1) : '0;
    cy_n = run ? ((cx != CX_LAST) ? cy : (cy == CY_LAST) ? '0 : cy + 1'b1) : '0;
  end

  assign v_line = cy_n >= VB;

  // Island sequencer: preamble, leading guard, back-to-back packet slots, trailing guard.
  always_comb begin
    state_n = state;
    cnt_n = cnt + 5'd1;
    slots_n = slots;
    case (state)
      CTRL: begin
        cnt_n = '0;
        if (ISL_OK && packet_valid && cx_n == ISL_X) state_n = ISL_PRE;
      end
      ISL_PRE: if (cnt == 5'd7) begin
        state_n = ISL_GUARD_L;
        cnt_n = '0;
      end
      ISL_GUARD_L: if (cnt == 5'd1) begin
        state_n = ISL_DATA;
        cnt_n = '0;
        slots_n = 8'd1;
      end
      ISL_DATA: if (cnt == 5'd31) begin
        if (packet_valid && slots < 8'(PKT_SLOTS)) slots_n = slots + 8'd1;
        else state_n = ISL_GUARD_T;
      end
      ISL_GUARD_T: if (cnt == 5'd1) begin
        state_n = CTRL;
        cnt_n = '0;
      end
      default: state_n = CTRL;
    endcase
  end

  // State and registered outputs; reset abandons any island immediately.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      run <= 1'b0;
      state <= CTRL;
      cnt <= '0;
      slots <= '0;
      cx <= '0;
      cy <= '0;
      hsync <= ~H_SYNC_POL;
      vsync <= ~V_SYNC_POL;
      mode <= 3'd0;
      ctrl <= 4'd0;
      packet_ready <= 1'b0;
      slot_cycle <= '0;
      frame_start <= 1'b0;
    end else begin
      run <= 1'b1;
      state <= state_n;
      cnt <= cnt_n;
      slots <= slots_n;
      cx <= cx_n;
      cy <= cy_n;
      hsync <= (cx_n >= HS_ON && cx_n < HS_OFF) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync <= (cy_n >= VS_ON && cy_n < VS_OFF) ? V_SYNC_POL : ~V_SYNC_POL;
      mode <= (state_n == ISL_DATA) ? 3'd3 :
              (state_n == ISL_GUARD_L || state_n == ISL_GUARD_T) ? 3'd4 :
              !v_line ? 3'd0 : (cx_n >= HB) ? 3'd1 : (cx_n >= HB_GRD) ? 3'd2 : 3'd0;
      ctrl <= (state_n == ISL_PRE) ? 4'b0101 :
              (v_line && cx_n >= HB_PRE && cx_n < HB_GRD) ? 4'b0001 : 4'b0000;
      packet_ready <= state_n == ISL_DATA && cnt_n == 5'd0;
      slot_cycle <= (state_n == ISL_DATA) ? cnt_n : 5'd0;
      frame_start <= cx_n == '0 && cy_n == '0;
    end
  end

  assign packet_first = packet_ready;
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen: directed checks of raster, syncs, video periods, islands, DVI mode and reset
module tb_hdmi_timing_gen;
  logic clk_pixel = 1'b0;
  logic reset_n = 1'b0;
  logic packet_valid = 1'b0;
  logic [11:0] cx, d_cx;
  logic [10:0] cy, d_cy;
  logic hsync, vsync, d_hsync, d_vsync;
  logic [2:0] mode, d_mode;
  logic [3:0] ctrl, d_ctrl;
  logic packet_ready, packet_first, d_packet_ready, d_packet_first;
  logic [4:0] slot_cycle, d_slot_cycle;
  logic frame_start, d_frame_start;
  int total = 0;
  int bad = 0;

  always #5 clk_pixel = ~clk_pixel;

  // vertical blanking kept at default (45 lines) with only 2 active lines so a whole frame is 800x47
  hdmi_timing_gen #(.V_ACTIVE(2)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_valid(packet_valid),
    .cx(cx), .cy(cy), .hsync(hsync), .vsync(vsync), .mode(mode), .ctrl(ctrl),
    .packet_ready(packet_ready), .packet_first(packet_first), .slot_cycle(slot_cycle),
    .frame_start(frame_start));

  hdmi_timing_gen #(.V_ACTIVE(2), .DVI_OUTPUT(1'b1)) dut_dvi (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_valid(packet_valid),
    .cx(d_cx), .cy(d_cy), .hsync(d_hsync), .vsync(d_vsync), .mode(d_mode), .ctrl(d_ctrl),
    .packet_ready(d_packet_ready), .packet_first(d_packet_first), .slot_cycle(d_slot_cycle),
    .frame_start(d_frame_start));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cx"}, cx, 0);
    check({tag, "_cy"}, cy, 0);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_ctrl"}, ctrl, 0);
    check({tag, "_ready"}, {packet_ready, packet_first}, 0);
    check({tag, "_slot"}, slot_cycle, 0);
    check({tag, "_fs"}, frame_start, 0);
  endtask

  // One blanking line with k expected packet slots (k=0: no island); valid is raised/dropped at the given cx.
  task automatic run_line(input string tag, input int y, input int k, input int last_x,
                          input int raise_x, input int drop_x);
    int e_pos = 0, e_mode = 0, e_ctrl = 0, e_rdy = 0, e_sc = 0, e_dvi = 0;
    int iend, em, ec, sc;
    iend = 12 + 32 * k;
    for (int x = 0; x <= last_x; x++) begin
      em = (k > 0 && (x == 10 || x == 11 || x == iend || x == iend + 1)) ? 4 :
           (k > 0 && x >= 12 && x < iend) ? 3 : 0;
      ec = (k > 0 && x >= 2 && x < 10) ? 5 : 0;
      sc = (em == 3) ? (x - 12) % 32 : 0;
      if (cx !== 12'(x) || cy !== 11'(y)) e_pos++;
      if (mode !== 3'(em)) e_mode++;
      if (ctrl !== 4'(ec)) e_ctrl++;
      if (packet_ready !== 1'(em == 3 && sc == 0) || packet_first !== 1'(em == 3 && sc == 0)) e_rdy++;
      if (slot_cycle !== 5'(sc)) e_sc++;
      if (d_packet_ready !== 1'b0 || d_mode !== 3'd0 || d_ctrl !== 4'd0) e_dvi++;
      if (x == raise_x) packet_valid = 1'b1;
      if (x == drop_x) packet_valid = 1'b0;
      @(negedge clk_pixel);
    end
    check({tag, "_pos"}, e_pos, 0);
    check({tag, "_mode"}, e_mode, 0);
    check({tag, "_ctrl"}, e_ctrl, 0);
    check({tag, "_ready"}, e_rdy, 0);
    check({tag, "_slot"}, e_sc, 0);
    check({tag, "_dvi"}, e_dvi, 0);
  endtask

  initial begin
    int e_pos, e_hs, e_vs, e_fs, e_mode, e_ctrl, e_rdy;
    repeat (3) @(negedge clk_pixel);
    check_reset_vals("rst_hold");
    reset_n = 1'b1;
    @(negedge clk_pixel);
    check("rel_cx", cx, 0);
    check("rel_cy", cy, 0);
    check("rel_fs", frame_start, 1);
    // full frame sweep with no packets
    e_pos = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_mode = 0; e_ctrl = 0; e_rdy = 0;
    for (int y = 0; y < 47; y++) begin
      for (int x = 0; x < 800; x++) begin
        if (cx !== 12'(x) || cy !== 11'(y)) e_pos++;
        if (hsync !== ((x >= 16 && x <= 111) ? 1'b0 : 1'b1)) e_hs++;
        if (vsync !== ((y == 10 || y == 11) ? 1'b0 : 1'b1)) e_vs++;
        if (frame_start !== 1'(x == 0 && y == 0)) e_fs++;
        if (mode !== ((y >= 45 && x >= 160) ? 3'd1 : (y >= 45 && x >= 158) ? 3'd2 : 3'd0)) e_mode++;
        if (ctrl !== ((y >= 45 && x >= 150 && x <= 157) ? 4'd1 : 4'd0)) e_ctrl++;
        if (packet_ready !== 1'b0 || slot_cycle !== 5'd0 || d_packet_ready !== 1'b0) e_rdy++;
        @(negedge clk_pixel);
      end
    end
    check("sweep_pos", e_pos, 0);
    check("sweep_hsync", e_hs, 0);
    check("sweep_vsync", e_vs, 0);
    check("sweep_fs", e_fs, 0);
    check("sweep_mode", e_mode, 0);
    check("sweep_ctrl", e_ctrl, 0);
    check("sweep_idle", e_rdy, 0);
    check("wrap_cx", cx, 0);
    check("wrap_cy", cy, 0);
    check("wrap_fs", frame_start, 1);
    // line 0: valid held all line -> three slots
    run_line("full", 0, 3, 799, 0, 799);
    // line 1: valid dropped after the first ready -> one slot
    run_line("single", 1, 1, 799, 0, 12);
    // line 2: valid raised at cx=5 -> ignored this line
    run_line("late", 2, 0, 799, 5, -1);
    // line 3: late valid now takes effect; stop at cx=30 mid-island
    run_line("next", 3, 3, 29, -1, -1);
    check("mid_cx", cx, 30);
    check("mid_mode", mode, 3);
    check("mid_slot", slot_cycle, 18);
    reset_n = 1'b0;
    packet_valid = 1'b0;
    #1;
    check_reset_vals("rst_async");
    @(negedge clk_pixel);
    check_reset_vals("rst_held");
    reset_n = 1'b1;
    @(negedge clk_pixel);
    check("restart_cx", cx, 0);
    check("restart_cy", cy, 0);
    check("restart_fs", frame_start, 1);
    check("restart_mode", mode, 0);
    @(negedge clk_pixel);
    check("restart_cx1", cx, 1);
    check("restart_fs1", frame_start, 0);
    @(negedge clk_pixel);
    check("restart_cx2", cx, 2);
    check("restart_ctrl2", ctrl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
